// File: rtl/fp_divider.sv
// IEEE-754 binary32 divider (z = a / b): restoring divide, one quotient bit per cycle,
// round-to-nearest-even, denormal inputs and results supported, stb/ack handshakes on all ports.
module fp_divider #(
    parameter logic [31:0] NAN_PATTERN = 32'hFFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT,
        DIVIDE, DIV_END, NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t             state_q, state_d;
    logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
    logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
    logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
    logic [26:0]        quo_q, quo_d;
    logic [25:0]        rem_q, rem_d, rem_diff;
    logic [4:0]         cnt_q, cnt_d;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Unpacked exponent 128 is the all-ones field, -127 the all-zeros field.
    assign a_nan  = (a_e_q == 10'sd128) && (a_m_q != 24'd0);
    assign b_nan  = (b_e_q == 10'sd128) && (b_m_q != 24'd0);
    assign a_inf  = (a_e_q == 10'sd128) && (a_m_q == 24'd0);
    assign b_inf  = (b_e_q == 10'sd128) && (b_m_q == 24'd0);
    assign a_zero = (a_e_q == -10'sd127) && (a_m_q == 24'd0);
    assign b_zero = (b_e_q == -10'sd127) && (b_m_q == 24'd0);
    assign rem_diff = rem_q - {2'b00, b_m_q};

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= GET_A;
            a_ack_q <= 1'b0;  b_ack_q <= 1'b0;  z_stb_q <= 1'b0;
            a_q <= '0;  b_q <= '0;  z_q <= '0;
            a_m_q <= '0;  b_m_q <= '0;  z_m_q <= '0;
            a_e_q <= '0;  b_e_q <= '0;  z_e_q <= '0;
            a_s_q <= 1'b0;  b_s_q <= 1'b0;  z_s_q <= 1'b0;
            guard_q <= 1'b0;  round_q <= 1'b0;  sticky_q <= 1'b0;
            quo_q <= '0;  rem_q <= '0;  cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_ack_q <= a_ack_d;  b_ack_q <= b_ack_d;  z_stb_q <= z_stb_d;
            a_q <= a_d;  b_q <= b_d;  z_q <= z_d;
            a_m_q <= a_m_d;  b_m_q <= b_m_d;  z_m_q <= z_m_d;
            a_e_q <= a_e_d;  b_e_q <= b_e_d;  z_e_q <= z_e_d;
            a_s_q <= a_s_d;  b_s_q <= b_s_d;  z_s_q <= z_s_d;
            guard_q <= guard_d;  round_q <= round_d;  sticky_q <= sticky_d;
            quo_q <= quo_d;  rem_q <= rem_d;  cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_ack_d = a_ack_q;  b_ack_d = b_ack_q;  z_stb_d = z_stb_q;
        a_d = a_q;  b_d = b_q;  z_d = z_q;
        a_m_d = a_m_q;  b_m_d = b_m_q;  z_m_d = z_m_q;
        a_e_d = a_e_q;  b_e_d = b_e_q;  z_e_d = z_e_q;
        a_s_d = a_s_q;  b_s_d = b_s_q;  z_s_d = z_s_q;
        guard_d = guard_q;  round_d = round_q;  sticky_d = sticky_q;
        quo_d = quo_q;  rem_d = rem_q;  cnt_d = cnt_q;

        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                a_m_d   = {1'b0, a_q[22:0]};
                b_m_d   = {1'b0, b_q[22:0]};
                a_e_d   = {2'b00, a_q[30:23]} - 10'sd127;
                b_e_d   = {2'b00, b_q[30:23]} - 10'sd127;
                a_s_d   = a_q[31];
                b_s_d   = b_q[31];
                state_d = SPECIAL;
            end
            SPECIAL: begin
                z_s_d   = a_s_q ^ b_s_q;
                z_stb_d = 1'b1;
                state_d = PUT_Z;
                if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
                    z_d = NAN_PATTERN;
                end else if (a_inf || b_zero) begin
                    z_d = {a_s_q ^ b_s_q, 8'hFF, 23'h0};
                end else if (a_zero || b_inf) begin
                    z_d = {a_s_q ^ b_s_q, 31'h0};
                end else begin
                    z_stb_d = 1'b0;
                    state_d = NORM_A;
                    if (a_e_q == -10'sd127) a_e_d = -10'sd126;
                    else                    a_m_d[23] = 1'b1;
                    if (b_e_q == -10'sd127) b_e_d = -10'sd126;
                    else                    b_m_d[23] = 1'b1;
                end
            end
            NORM_A: begin
                if (!a_m_q[23]) begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - 10'sd1;
                end else begin
                    state_d = NORM_B;
                end
            end
            NORM_B: begin
                if (!b_m_q[23]) begin
                    b_m_d = b_m_q << 1;
                    b_e_d = b_e_q - 10'sd1;
                end else begin
                    state_d = DIV_INIT;
                end
            end
            DIV_INIT: begin
                z_e_d   = a_e_q - b_e_q;
                rem_d   = {2'b00, a_m_q};
                cnt_d   = 5'd26;
                quo_d   = '0;
                state_d = DIVIDE;
            end
            DIVIDE: begin
                if (rem_q >= {2'b00, b_m_q}) begin
                    quo_d = quo_q | (27'd1 << cnt_q);
                    rem_d = rem_diff << 1;
                end else begin
                    rem_d = rem_q << 1;
                end
                if (cnt_q == 5'd0) state_d = DIV_END;
                else               cnt_d   = cnt_q - 5'd1;
            end
            DIV_END: begin
                z_m_d    = quo_q[26:3];
                guard_d  = quo_q[2];
                round_d  = quo_q[1];
                sticky_d = quo_q[0] | (rem_q != 26'd0);
                state_d  = NORM_1;
            end
            NORM_1: begin
                if (!z_m_q[23]) begin
                    z_m_d   = {z_m_q[22:0], guard_q};
                    guard_d = round_q;
                    round_d = 1'b0;
                    z_e_d   = z_e_q - 10'sd1;
                end
                state_d = NORM_2;
            end
            NORM_2: begin
                // Denormalise toward the minimum exponent, folding lost bits into sticky.
                if (z_e_q < -10'sd126) begin
                    z_m_d    = z_m_q >> 1;
                    z_e_d    = z_e_q + 10'sd1;
                    guard_d  = z_m_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 24'd1;
                    if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
                end
                state_d = PACK;
            end
            PACK: begin
                z_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
                if ((z_e_q == -10'sd126) && !z_m_q[23]) z_d[30:23] = 8'h00;
                if (z_e_q > 10'sd127) z_d = {z_s_q, 8'hFF, 23'h0};
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end
endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: arithmetic, specials, range limits,
// backpressure, mid-operation reset and latency.
module tb_fp_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] input_a = '0, input_b = '0;
    logic        input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0;
    logic        input_a_ack, input_b_ack, output_z_stb;
    logic [31:0] output_z;

    int total = 0;
    int bad   = 0;

    fp_divider dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input string tag);
        bit seen;
        input_a = a; input_a_stb = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (input_a_ack) seen = 1;
        end
        if (!seen) check({tag, "_a_ack_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_b = b; input_b_stb = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (input_b_ack) seen = 1;
        end
        if (!seen) check({tag, "_b_ack_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        input_b_stb = 1'b0;
    endtask

    // Waits for output_z_stb; lat counts negedges since the input_b transfer.
    task automatic wait_z(input string tag, output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (output_z_stb) seen = 1;
        end
        if (!seen) check({tag, "_z_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic ack_z();
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input string tag, input bit chk_lat);
        int lat;
        send(a, b, tag);
        wait_z(tag, lat);
        check(tag, output_z, exp);
        if (chk_lat) check({tag, "_lat_le40"}, 32'(lat <= 40), 32'd1);
        ack_z();
    endtask

    initial begin
        logic [31:0] held;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        check("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        check("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
        check("rst_z", output_z, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel_a_ack", {31'd0, input_a_ack}, 32'd1);

        run(32'h40C00000, 32'h40000000, 32'h40400000, "6div2", 1'b1);
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1div3", 1'b1);
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1div3_again", 1'b0);
        run(32'hC1200000, 32'h40A00000, 32'hC0000000, "m10div5", 1'b1);
        run(32'h3F800000, 32'h00000000, 32'h7F800000, "1div0", 1'b0);
        run(32'h00000000, 32'h00000000, 32'hFFC00000, "0div0", 1'b0);
        run(32'hBF800000, 32'h7F800000, 32'h80000000, "m1divinf", 1'b0);
        run(32'h7FC00000, 32'h3F800000, 32'hFFC00000, "nandiv1", 1'b0);
        run(32'h7F800000, 32'h7F800000, 32'hFFC00000, "infdivinf", 1'b0);
        run(32'hFF800000, 32'h40000000, 32'hFF800000, "minfdiv2", 1'b0);
        run(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, "overflow", 1'b0);
        run(32'h00800000, 32'h40000000, 32'h00400000, "denorm_res", 1'b0);
        run(32'h00000001, 32'h3F000000, 32'h00000002, "min_denorm", 1'b0);
        run(32'h00000001, 32'h7F000000, 32'h00000000, "underflow", 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        send(32'h40C00000, 32'h40000000, "bp");
        wait_z("bp", lat);
        held = output_z;
        check("bp_first", held, 32'h40400000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stb_hold", {31'd0, output_z_stb}, 32'd1);
            check("bp_z_hold", output_z, held);
        end
        ack_z();
        @(negedge clk);
        check("bp_stb_drop", {31'd0, output_z_stb}, 32'd0);

        // Reset in the middle of the divide loop.
        send(32'h3F800000, 32'h40400000, "rstmid");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid_a_ack", {31'd0, input_a_ack}, 32'd0);
        check("rstmid_b_ack", {31'd0, input_b_ack}, 32'd0);
        check("rstmid_z_stb", {31'd0, output_z_stb}, 32'd0);
        check("rstmid_z", output_z, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_rel_a_ack", {31'd0, input_a_ack}, 32'd1);
        run(32'h40C00000, 32'h40000000, 32'h40400000, "after_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
